// File: rtl/fft_vga_pkg.sv
// rtl/fft_vga_pkg.sv - shared defaults, FSM states and magnitude helpers for the FFT-to-VGA path
package fft_vga_pkg;

  localparam int NUM_BINS_DEFAULT = 512;
  localparam int ADDR_W_DEFAULT   = 10;

  typedef enum logic [1:0] {IDLE, WRITE, SKIP} state_t;

  // |-32768| = 32768 still fits the unsigned 16-bit result
  function automatic logic [15:0] abs16(input logic [15:0] v);
    return v[15] ? 16'(~v + 16'd1) : v;
  endfunction

  // alpha-max-beta-min; worst case 32768 + 16384 needs no saturation
  function automatic logic [15:0] mag(input logic [15:0] mx, input logic [15:0] mn);
    return mx + (mn >> 1);
  endfunction

endpackage

// File: rtl/fft_mag_approx.sv
// rtl/fft_mag_approx.sv - two-stage registered magnitude pipe with sideband carried alongside
module fft_mag_approx
  import fft_vga_pkg::*;
#(
  parameter int SB_W = 11
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic [15:0]     in_re,
  input  logic [15:0]     in_im,
  input  logic [SB_W-1:0] in_sb,
  output logic            out_valid,
  output logic [15:0]     out_mag,
  output logic [SB_W-1:0] out_sb
);

  logic [15:0]     a, b;
  logic            s1_valid;
  logic [15:0]     s1_max, s1_min;
  logic [SB_W-1:0] s1_sb;

  assign a = abs16(in_re);
  assign b = abs16(in_im);

  // Idle slots are zeroed so the RAM-facing outputs sit at 0 between writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_max    <= '0;
      s1_min    <= '0;
      s1_sb     <= '0;
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_sb    <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_max    <= in_valid ? ((a >= b) ? a : b) : '0;
      s1_min    <= in_valid ? ((a >= b) ? b : a) : '0;
      s1_sb     <= in_valid ? in_sb : '0;
      out_valid <= s1_valid;
      out_mag   <= mag(s1_max, s1_min);
      out_sb    <= s1_sb;
    end
  end

endmodule

// File: rtl/fft_bin_writer.sv
// rtl/fft_bin_writer.sv - framed FFT bin stream to double-buffered display RAM writer
module fft_bin_writer
  import fft_vga_pkg::*;
#(
  parameter int NUM_BINS = NUM_BINS_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [3:0]        ram_byteenable,
  output logic [31:0]       ram_writedata,
  output logic              ram_clken,
  output logic              display_bank,
  output logic              frame_done,
  output logic [7:0]        frame_err_count
);

  localparam int BIN_W = ADDR_W - 1;
  localparam int SB_W  = ADDR_W + 1;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d, beat_bin;
  logic             ready_q, accept;
  logic             beat_wr, beat_commit, err_inc;
  logic             wr_bank_q, display_bank_q, frame_done_q;
  logic [7:0]       err_q;
  logic [SB_W-1:0]  pipe_in_sb, pipe_sb;
  logic             pipe_valid;
  logic [15:0]      pipe_mag;

  assign accept = in_valid & ready_q;

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    beat_bin    = bin_q;
    beat_wr     = 1'b0;
    beat_commit = 1'b0;
    err_inc     = 1'b0;
    if (accept) begin
      if (in_sop || state_q == WRITE) begin
        beat_wr  = 1'b1;
        beat_bin = in_sop ? '0 : bin_q;
        bin_d    = beat_bin + 1'b1;
        state_d  = WRITE;
        err_inc  = in_sop && (state_q == WRITE);
        if (in_eop) begin
          state_d = IDLE;
          if (beat_bin == LAST_BIN) beat_commit = 1'b1;
          else                      err_inc     = 1'b1;
        end else if (beat_bin == LAST_BIN) begin
          state_d = SKIP;
          err_inc = 1'b1;
        end
      end else if (state_q == SKIP && in_eop) begin
        state_d = IDLE;
      end
    end
  end

  // Write bank flips as soon as the committing beat is accepted so a frame
  // starting on the very next cycle already targets the other half.
  assign pipe_in_sb = {beat_commit, wr_bank_q, beat_bin};

  fft_mag_approx #(.SB_W(SB_W)) u_mag (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (beat_wr),
    .in_re     (in_data[31:16]),
    .in_im     (in_data[15:0]),
    .in_sb     (pipe_in_sb),
    .out_valid (pipe_valid),
    .out_mag   (pipe_mag),
    .out_sb    (pipe_sb)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      bin_q          <= '0;
      ready_q        <= 1'b0;
      wr_bank_q      <= 1'b1;
      display_bank_q <= 1'b0;
      frame_done_q   <= 1'b0;
      err_q          <= '0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      ready_q      <= 1'b1;
      frame_done_q <= pipe_valid & pipe_sb[ADDR_W];
      if (beat_commit) wr_bank_q <= ~wr_bank_q;
      if (pipe_valid & pipe_sb[ADDR_W]) display_bank_q <= ~display_bank_q;
      if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  assign in_ready        = ready_q;
  assign ram_address     = pipe_sb[ADDR_W-1:0];
  assign ram_chipselect  = pipe_valid;
  assign ram_write       = pipe_valid;
  assign ram_byteenable  = 4'hF;
  assign ram_writedata   = {16'd0, pipe_mag};
  assign ram_clken       = 1'b1;
  assign display_bank    = display_bank_q;
  assign frame_done      = frame_done_q;
  assign frame_err_count = err_q;

endmodule

// File: tb/tb_fft_bin_writer.sv
// tb/tb_fft_bin_writer.sv - scoreboard bench for fft_bin_writer
module tb_fft_bin_writer;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic [9:0]  ram_address;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic        display_bank, frame_done;
  logic [7:0]  frame_err_count;

  wr_t  sb_q[$];
  logic disp_at_done[$];
  wr_t  got;
  int   n_assert = 0, n_fail = 0;
  int   cyc = 0, done_count = 0, done_cyc = -1, last_cyc = 0;
  logic prev_disp = 1'b0;

  fft_bin_writer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_sop          (in_sop),
    .in_eop          (in_eop),
    .ram_address     (ram_address),
    .ram_chipselect  (ram_chipselect),
    .ram_write       (ram_write),
    .ram_byteenable  (ram_byteenable),
    .ram_writedata   (ram_writedata),
    .ram_clken       (ram_clken),
    .display_bank    (display_bank),
    .frame_done      (frame_done),
    .frame_err_count (frame_err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_mag(input int re, input int im);
    int a, b;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    return (a > b) ? 32'(a + b / 2) : 32'(b + a / 2);
  endfunction

  always @(negedge clk) begin
    if (ram_write === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", {22'd0, ram_address}, 32'hFFFF_FFFF);
      end else begin
        got = sb_q.pop_front();
        check("write_addr", {22'd0, ram_address}, {22'd0, got.addr});
        check("write_data", ram_writedata, got.data);
        check("write_cycle", cyc, got.cyc);
        check("chipselect", {31'd0, ram_chipselect}, 32'd1);
      end
    end
    if (frame_done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
      disp_at_done.push_back(display_bank);
      check("bank_toggle_at_done", {31'd0, display_bank}, {31'd0, ~prev_disp});
    end
    prev_disp = display_bank;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic signed [15:0] re, input logic signed [15:0] im,
                      input logic sop, input logic eop, input logic wr,
                      input logic [9:0] addr, input logic [31:0] data);
    wr_t w;
    check("in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = {re, im};
    in_sop   = sop;
    in_eop   = eop;
    last_cyc = cyc;
    if (wr) begin
      w.addr = addr;
      w.data = data;
      w.cyc  = cyc + 2;
      sb_q.push_back(w);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  // random-data frame: sop at index 0, eop on the last beat, first nwrites expected
  task automatic run_frame(input logic bank, input int first, input int nbeats, input int nwrites);
    logic signed [15:0] re, im;
    for (int i = first; i < nbeats; i++) begin
      re = 16'($urandom);
      im = 16'($urandom);
      beat(re, im, i == 0, i == nbeats - 1, i < nwrites, {bank, 9'(i)}, exp_mag(re, im));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_write"}, {31'd0, ram_write}, 32'd0);
    check({tag, "_ram_cs"}, {31'd0, ram_chipselect}, 32'd0);
    check({tag, "_ram_addr"}, {22'd0, ram_address}, 32'd0);
    check({tag, "_ram_data"}, ram_writedata, 32'd0);
    check({tag, "_byteenable"}, {28'd0, ram_byteenable}, 32'hF);
    check({tag, "_clken"}, {31'd0, ram_clken}, 32'd1);
    check({tag, "_display_bank"}, {31'd0, display_bank}, 32'd0);
    check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_err_count"}, {24'd0, frame_err_count}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    idle(3);

    // Frame A into bank 1: 3-4j then zeros
    beat(16'sd3, -16'sd4, 1'b1, 1'b0, 1'b1, 10'd512, 32'd5);
    for (int i = 1; i < 512; i++)
      beat(16'sd0, 16'sd0, 1'b0, i == 511, 1'b1, 10'(512 + i), 32'd0);
    idle(6);
    check("a_done_count", done_count, 1);
    check("a_done_cycle", done_cyc, last_cyc + 3);
    check("a_display_bank", {31'd0, display_bank}, 32'd1);
    check("a_err", {24'd0, frame_err_count}, 32'd0);

    // Frames B (bank 0) and C (bank 1) back to back
    beat(16'sd100, 16'sd0, 1'b1, 1'b0, 1'b1, 10'd0, 32'd100);
    beat(-16'sd32768, -16'sd32768, 1'b0, 1'b0, 1'b1, 10'd1, 32'h0000_C000);
    run_frame(1'b0, 2, 512, 512);
    run_frame(1'b1, 0, 512, 512);
    idle(6);
    check("bc_done_count", done_count, 3);
    check("c_done_cycle", done_cyc, last_cyc + 3);
    check("b_display_bank", {31'd0, disp_at_done[1]}, 32'd0);
    check("c_display_bank", {31'd0, disp_at_done[2]}, 32'd1);
    check("bc_err", {24'd0, frame_err_count}, 32'd0);

    // Short frame: eop at bin 10
    run_frame(1'b0, 0, 11, 11);
    idle(6);
    check("short_err", {24'd0, frame_err_count}, 32'd1);
    check("short_display_bank", {31'd0, display_bank}, 32'd1);
    check("short_done_count", done_count, 3);

    // Non-sop beats in IDLE are dropped
    beat(16'sd7, 16'sd9, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    beat(16'sd7, 16'sd9, 1'b0, 1'b1, 1'b0, 10'd0, 32'd0);

    // Long frame: 600 beats without eop, then eop
    run_frame(1'b0, 0, 601, 512);
    idle(6);
    check("long_err", {24'd0, frame_err_count}, 32'd2);
    check("long_display_bank", {31'd0, display_bank}, 32'd1);
    check("long_done_count", done_count, 3);

    // Asynchronous reset at bin 200; the two beats still in the pipe are lost
    for (int i = 0; i < 200; i++)
      beat(16'sd50, 16'sd20, i == 0, 1'b0, i < 198, 10'(i), 32'd60);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    idle(3);
    reset_n = 1'b1;
    idle(3);
    run_frame(1'b1, 0, 512, 512);
    idle(6);
    check("post_reset_done_count", done_count, 4);
    check("post_reset_display_bank", {31'd0, display_bank}, 32'd1);
    check("post_reset_err", {24'd0, frame_err_count}, 32'd0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
